cache_bus_bridge: RTL and testbench

Bus-side neighbour of the L1 cache. It converts the cache's line-level requests into AHB-Lite incrementing bursts and manages the beats in both directions. Line fetches are collected beat by beat into `FetchBuffer` for the cache to fill and early-return. Dirty-line writebacks are streamed out by driving `BeatCount`/`SelBusBeat` into the cache's word-select mux. One instance sits between each of I$ and D$ and the bus arbiter (the I$ instance ties off the writeback path).

---
 rtl/cache_bus_bridge_pkg.sv | 30 +++
 rtl/cache_bus_bridge_busbeatcounter.sv | 23 ++
 rtl/cache_bus_bridge.sv | 184 ++++++++++++++++++
 tb/tb_cache_bus_bridge.sv | 277 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/cache_bus_bridge_pkg.sv
// Shared AHB-Lite encodings and the bridge FSM state type.
package cache_bus_bridge_pkg;

  localparam logic [1:0] HTRANS_IDLE   = 2'b00;
  localparam logic [1:0] HTRANS_NONSEQ = 2'b10;
  localparam logic [1:0] HTRANS_SEQ    = 2'b11;

  localparam logic [2:0] HBURST_SINGLE = 3'b000;
  localparam logic [2:0] HBURST_INCR   = 3'b001;
  localparam logic [2:0] HBURST_INCR4  = 3'b011;
  localparam logic [2:0] HBURST_INCR8  = 3'b101;
  localparam logic [2:0] HBURST_INCR16 = 3'b111;

  typedef enum logic [1:0] {
    STATE_IDLE = 2'b00,
    STATE_ADDR = 2'b01,
    STATE_DATA = 2'b10
  } busState_t;

  function automatic logic [2:0] burstFor(input int beats);
    case (beats)
      1:       return HBURST_SINGLE;
      4:       return HBURST_INCR4;
      8:       return HBURST_INCR8;
      16:      return HBURST_INCR16;
      default: return HBURST_INCR;
    endcase
  endfunction

endpackage

// File: rtl/cache_bus_bridge_busbeatcounter.sv
// Enabled modulo-BEATS beat counter with a flag on the final beat.
module busbeatcounter #(
  parameter int BEATS = 8,
  parameter int W     = 3
) (
  input  logic         clk,
  input  logic         reset_n,
  input  logic         Enable,
  output logic [W-1:0] Count,
  output logic         LastBeat
);

  assign LastBeat = (Count == W'(BEATS - 1));

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      Count <= '0;
    end else if (Enable) begin
      Count <= LastBeat ? '0 : Count + W'(1);
    end
  end

endmodule

// File: rtl/cache_bus_bridge.sv
// Turns cache line fetch/writeback requests into AHB-Lite incrementing bursts,
// assembling fetched beats into FetchBuffer and streaming writeback words out.
module cache_bus_bridge
  import cache_bus_bridge_pkg::*;
#(
  parameter int PA_BITS         = 34,
  parameter int AHBW            = 64,
  parameter int LINELEN         = 512,
  parameter int LOGBWPL         = 3,
  parameter bit READ_ONLY_CACHE = 1'b0
) (
  input  logic               clk,
  input  logic               reset_n,
  input  logic               FlushStage,
  input  logic [1:0]         CacheBusRW,
  input  logic [PA_BITS-1:0] CacheBusAdr,
  input  logic [AHBW-1:0]    ReadDataWord,
  output logic               CacheBusAck,
  output logic               SelBusBeat,
  output logic [LOGBWPL-1:0] BeatCount,
  output logic [LINELEN-1:0] FetchBuffer,
  output logic               BusCommitted,
  output logic [PA_BITS-1:0] HADDR,
  output logic [1:0]         HTRANS,
  output logic               HWRITE,
  output logic [2:0]         HBURST,
  output logic [2:0]         HSIZE,
  output logic [AHBW-1:0]    HWDATA,
  input  logic               HREADY,
  input  logic [AHBW-1:0]    HRDATA,
  output logic [1:0]         DebugState
);

  localparam int         BEATS     = LINELEN / AHBW;
  localparam int         BYTES     = AHBW / 8;
  localparam logic [2:0] BURST_ENC = burstFor(BEATS);
  localparam logic [2:0] SIZE_ENC  = 3'($clog2(BYTES));

  busState_t          state;
  logic [PA_BITS-1:0] haddrReg;
  logic [1:0]         htransReg;
  logic               hwriteReg;
  logic [2:0]         hburstReg;
  logic [2:0]         hsizeReg;
  logic               selBusBeatReg;
  logic               busCommittedReg;
  logic               dataActive;

  logic [LOGBWPL-1:0] addrCount;
  logic [LOGBWPL-1:0] dataCount;
  logic               addrLast;
  logic               dataLast;

  logic reqWrite;
  logic reqValid;
  logic startReq;
  logic addrPhase;
  logic addrAccept;
  logic dataDone;

  // Handshake: an address phase (HTRANS != IDLE) is accepted, and an open data
  // phase completes, only in a cycle with HREADY=1; HREADY=0 freezes both.
  assign reqWrite   = !READ_ONLY_CACHE && CacheBusRW[0];
  assign reqValid   = CacheBusRW[1] || reqWrite;
  assign startReq   = reset_n && (state == STATE_IDLE) && reqValid && !FlushStage;
  assign addrPhase  = startReq || (state == STATE_ADDR);
  assign addrAccept = addrPhase && HREADY;
  assign dataDone   = dataActive && HREADY;

  busbeatcounter #(.BEATS(BEATS), .W(LOGBWPL)) u_addrCounter (
    .clk      (clk),
    .reset_n  (reset_n),
    .Enable   (addrAccept),
    .Count    (addrCount),
    .LastBeat (addrLast)
  );

  busbeatcounter #(.BEATS(BEATS), .W(LOGBWPL)) u_dataCounter (
    .clk      (clk),
    .reset_n  (reset_n),
    .Enable   (dataDone),
    .Count    (dataCount),
    .LastBeat (dataLast)
  );

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state           <= STATE_IDLE;
      haddrReg        <= '0;
      htransReg       <= HTRANS_IDLE;
      hwriteReg       <= 1'b0;
      hburstReg       <= '0;
      hsizeReg        <= '0;
      selBusBeatReg   <= 1'b0;
      busCommittedReg <= 1'b0;
      dataActive      <= 1'b0;
      FetchBuffer     <= '0;
    end else begin
      case (state)
        STATE_IDLE: begin
          if (startReq) begin
            hwriteReg     <= reqWrite;
            hburstReg     <= BURST_ENC;
            hsizeReg      <= SIZE_ENC;
            selBusBeatReg <= 1'b1;
            if (HREADY) begin
              busCommittedReg <= 1'b1;
              if (addrLast) begin
                state     <= STATE_DATA;
                htransReg <= HTRANS_IDLE;
                haddrReg  <= CacheBusAdr;
              end else begin
                state     <= STATE_ADDR;
                htransReg <= HTRANS_SEQ;
                haddrReg  <= CacheBusAdr + PA_BITS'(BYTES);
              end
            end else begin
              // Beat 0 stalled: keep offering it as a registered NONSEQ.
              state     <= STATE_ADDR;
              htransReg <= HTRANS_NONSEQ;
              haddrReg  <= CacheBusAdr;
            end
          end
        end
        STATE_ADDR: begin
          if (HREADY) begin
            busCommittedReg <= 1'b1;
            if (addrLast) begin
              state     <= STATE_DATA;
              htransReg <= HTRANS_IDLE;
            end else begin
              htransReg <= HTRANS_SEQ;
              haddrReg  <= haddrReg + PA_BITS'(BYTES);
            end
          end
        end
        STATE_DATA: begin
          if (CacheBusAck) begin
            state           <= STATE_IDLE;
            busCommittedReg <= 1'b0;
            selBusBeatReg   <= 1'b0;
          end
        end
        default: state <= STATE_IDLE;
      endcase

      if (HREADY) begin
        dataActive <= addrAccept;
      end
      if (dataDone && !hwriteReg) begin
        FetchBuffer[dataCount*AHBW +: AHBW] <= HRDATA;
      end
    end
  end

  generate
    if (READ_ONLY_CACHE) begin : g_noWriteback
      assign HWDATA = '0;
    end else begin : g_writeback
      logic [AHBW-1:0] hwdataReg;
      always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
          hwdataReg <= '0;
        end else if (addrAccept) begin
          hwdataReg <= ReadDataWord;
        end
      end
      assign HWDATA = hwdataReg;
    end
  endgenerate

  // The first address phase leaves IDLE in the same cycle the request arrives.
  assign HTRANS       = startReq ? HTRANS_NONSEQ : htransReg;
  assign HADDR        = startReq ? CacheBusAdr   : haddrReg;
  assign HWRITE       = startReq ? reqWrite      : hwriteReg;
  assign HBURST       = startReq ? BURST_ENC     : hburstReg;
  assign HSIZE        = startReq ? SIZE_ENC      : hsizeReg;
  assign CacheBusAck  = (state == STATE_DATA) && dataDone && dataLast;
  assign BeatCount    = addrCount;
  assign SelBusBeat   = selBusBeatReg;
  assign BusCommitted = busCommittedReg;
  assign DebugState   = state;

endmodule

// File: tb/tb_cache_bus_bridge.sv
// Directed bench for cache_bus_bridge: expected bus traffic is queued by the
// drivers and consumed by a negedge monitor.
module tb_cache_bus_bridge;

  logic         clk;
  logic         reset_n;
  logic         FlushStage;
  logic [1:0]   CacheBusRW;
  logic [33:0]  CacheBusAdr;
  logic [63:0]  ReadDataWord;
  logic         CacheBusAck;
  logic         SelBusBeat;
  logic [2:0]   BeatCount;
  logic [511:0] FetchBuffer;
  logic         BusCommitted;
  logic [33:0]  HADDR;
  logic [1:0]   HTRANS;
  logic         HWRITE;
  logic [2:0]   HBURST;
  logic [2:0]   HSIZE;
  logic [63:0]  HWDATA;
  logic         HREADY;
  logic [63:0]  HRDATA;
  logic [1:0]   DebugState;

  cache_bus_bridge dut (
    .clk          (clk),
    .reset_n      (reset_n),
    .FlushStage   (FlushStage),
    .CacheBusRW   (CacheBusRW),
    .CacheBusAdr  (CacheBusAdr),
    .ReadDataWord (ReadDataWord),
    .CacheBusAck  (CacheBusAck),
    .SelBusBeat   (SelBusBeat),
    .BeatCount    (BeatCount),
    .FetchBuffer  (FetchBuffer),
    .BusCommitted (BusCommitted),
    .HADDR        (HADDR),
    .HTRANS       (HTRANS),
    .HWRITE       (HWRITE),
    .HBURST       (HBURST),
    .HSIZE        (HSIZE),
    .HWDATA       (HWDATA),
    .HREADY       (HREADY),
    .HRDATA       (HRDATA),
    .DebugState   (DebugState)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout required finish");
    $fatal(1);
  end

  // Cache word mux model: the word selected by BeatCount.
  assign ReadDataWord = 64'hA0 + 64'(BeatCount);

  // ---------------- scoreboard ----------------
  int checks = 0;
  int errors = 0;

  logic [42:0] exp_addr_q[$];   // {HTRANS, HWRITE, HBURST, HSIZE, HADDR}
  logic [63:0] exp_wdata_q[$];
  int          exp_ack_q[$];

  task automatic check(input string name, input logic [511:0] act, input logic [511:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic fail_now(input string name, input logic [511:0] act);
    checks++;
    errors++;
    $display("FAIL %s: got %0h expected nothing (cycle %0d)", name, act, cyc);
  endtask

  function automatic logic [63:0] fetch_word(input int tag, input int k);
    return 64'hCAFE_0000_0000_0000 | (64'(tag) << 32) | 64'(k);
  endfunction

  task automatic push_addr(input logic [33:0] adr, input logic wr, input int b);
    exp_addr_q.push_back({(b == 0) ? 2'b10 : 2'b11, wr, 3'b101, 3'b011, adr + 34'(8 * b)});
  endtask

  // ---------------- monitor ----------------
  logic d_pend  = 1'b0;
  logic d_write = 1'b0;

  always @(negedge clk) begin
    if (!reset_n) begin
      d_pend = 1'b0;
    end else begin
      if (HTRANS != 2'b00) begin
        if (exp_addr_q.size() == 0) fail_now("unexpected_addr_phase", 512'({HTRANS, HADDR}));
        else begin
          check("addr_phase", 512'({HTRANS, HWRITE, HBURST, HSIZE, HADDR}), 512'(exp_addr_q[0]));
          if (HREADY) void'(exp_addr_q.pop_front());
        end
      end
      if (d_pend && d_write) begin
        if (exp_wdata_q.size() == 0) fail_now("unexpected_wdata", 512'(HWDATA));
        else begin
          check("hwdata", 512'(HWDATA), 512'(exp_wdata_q[0]));
          if (HREADY) void'(exp_wdata_q.pop_front());
        end
      end
      if (HREADY) begin
        d_pend  = (HTRANS != 2'b00);
        d_write = HWRITE;
      end
      if (CacheBusAck) begin
        if (exp_ack_q.size() == 0) fail_now("unexpected_ack", 512'(cyc));
        else check("ack_cycle", 512'(cyc), 512'(exp_ack_q.pop_front()));
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_htrans"}, 512'(HTRANS), 512'(0));
    check({tag, "_haddr"}, 512'(HADDR), 512'(0));
    check({tag, "_hwrite"}, 512'(HWRITE), 512'(0));
    check({tag, "_hburst"}, 512'(HBURST), 512'(0));
    check({tag, "_hsize"}, 512'(HSIZE), 512'(0));
    check({tag, "_hwdata"}, 512'(HWDATA), 512'(0));
    check({tag, "_fetchbuf"}, FetchBuffer, 512'(0));
    check({tag, "_beatcount"}, 512'(BeatCount), 512'(0));
    check({tag, "_selbusbeat"}, 512'(SelBusBeat), 512'(0));
    check({tag, "_ack"}, 512'(CacheBusAck), 512'(0));
    check({tag, "_committed"}, 512'(BusCommitted), 512'(0));
    check({tag, "_state"}, 512'(DebugState), 512'(0));
  endtask

  // Starts in the current cycle (cycle 0), zero-wait, ends after checking the
  // line in cycle 9 with the request dropped.
  task automatic do_fetch(input logic [33:0] adr, input int tag, input int flush_at);
    logic [511:0] exp_fb;
    int start;
    for (int b = 0; b < 8; b++) push_addr(adr, 1'b0, b);
    CacheBusRW  = 2'b10;
    CacheBusAdr = adr;
    HREADY      = 1'b1;
    start       = cyc;
    exp_ack_q.push_back(start + 8);
    @(negedge clk);
    check("fetch_nonseq_now", 512'(HTRANS), 512'(2'b10));
    for (int k = 1; k <= 8; k++) begin
      next_cycle();
      HRDATA = fetch_word(tag, k - 1);
      if (k == flush_at) FlushStage = 1'b1;
      if (k == 1) begin
        @(negedge clk);
        check("fetch_committed", 512'(BusCommitted), 512'(1));
        check("fetch_selbusbeat", 512'(SelBusBeat), 512'(1));
      end
    end
    next_cycle();
    CacheBusRW = 2'b00;
    FlushStage = 1'b0;
    for (int k = 0; k < 8; k++) exp_fb[k*64 +: 64] = fetch_word(tag, k);
    @(negedge clk);
    check("fetch_line", FetchBuffer, exp_fb);
    check("fetch_released", 512'(BusCommitted), 512'(0));
    check("fetch_idle_state", 512'(DebugState), 512'(0));
  endtask

  // Starts in cycle 0; HREADY is low in each cycle whose bit is set in waits.
  // Ends at the negedge of the Ack cycle with the request still held.
  task automatic do_wb(input logic [33:0] adr, input logic [15:0] waits);
    int n;
    n = 8 + $countones(waits);
    for (int b = 0; b < 8; b++) begin
      push_addr(adr, 1'b1, b);
      exp_wdata_q.push_back(64'hA0 + 64'(b));
    end
    CacheBusRW  = 2'b01;
    CacheBusAdr = adr;
    HREADY      = !waits[0];
    exp_ack_q.push_back(cyc + n);
    for (int k = 1; k <= n; k++) begin
      next_cycle();
      HREADY = !waits[k];
    end
    @(negedge clk);
    check("wb_ack_cycle_htrans", 512'(HTRANS), 512'(0));
  endtask

  // ---------------- stimulus ----------------
  initial begin
    reset_n     = 1'b0;
    FlushStage  = 1'b0;
    CacheBusRW  = 2'b10;
    CacheBusAdr = 34'h0_8000_0000;
    HREADY      = 1'b1;
    HRDATA      = '0;

    // Reset holds everything at zero even with a request pending.
    @(negedge clk);
    check_all_zero("reset");
    next_cycle();
    reset_n    = 1'b1;
    CacheBusRW = 2'b00;
    next_cycle();

    // Flush before start: never leaves IDLE.
    FlushStage = 1'b1;
    CacheBusRW = 2'b10;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      check("flush_htrans_idle", 512'(HTRANS), 512'(0));
      check("flush_state_idle", 512'(DebugState), 512'(0));
      next_cycle();
    end
    FlushStage = 1'b0;
    CacheBusRW = 2'b00;
    next_cycle();

    // Zero-wait fetch.
    do_fetch(34'h0_8000_0040, 1, 0);
    next_cycle();

    // Writeback with waits in cycles 2 and 5, then back-to-back fetch.
    do_wb(34'h0_8000_0100, 16'h0024);
    next_cycle();
    do_fetch(34'h0_0000_1000, 2, 0);
    next_cycle();

    // Flush mid-burst is ignored.
    do_fetch(34'h0_4000_0080, 3, 2);
    next_cycle();

    // Reset in the beat 3 address phase.
    for (int b = 0; b < 3; b++) push_addr(34'h0_8000_0200, 1'b0, b);
    CacheBusRW  = 2'b10;
    CacheBusAdr = 34'h0_8000_0200;
    for (int k = 1; k <= 3; k++) begin
      next_cycle();
      HRDATA = fetch_word(4, k - 1);
    end
    reset_n = 1'b0;
    @(negedge clk);
    check_all_zero("midreset");
    next_cycle();
    @(negedge clk);
    check("reset_gates_request", 512'(HTRANS), 512'(0));
    next_cycle();
    reset_n    = 1'b1;
    CacheBusRW = 2'b00;
    next_cycle();
    do_fetch(34'h0_8000_0200, 5, 0);
    next_cycle();
    next_cycle();

    check("addr_queue_drained", 512'(exp_addr_q.size()), 512'(0));
    check("wdata_queue_drained", 512'(exp_wdata_q.size()), 512'(0));
    check("ack_queue_drained", 512'(exp_ack_q.size()), 512'(0));

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
